// File: rtl/jump_redirect_unit_pkg.sv
// Shared constants and state encoding for the jump redirect unit and its target calculator.
package jump_redirect_unit_pkg;

    localparam int   BITS32   = 32;
    localparam logic TRUE     = 1'b1;
    localparam logic FALSE    = 1'b0;
    localparam int   LINK_INC = 4;

    typedef enum logic [1:0] {
        JRU_IDLE     = 2'd0,
        JRU_REDIRECT = 2'd1,
        JRU_FLUSH    = 2'd2
    } jru_state_e;

endpackage

// File: rtl/jump_redirect_unit_target_calc.sv
// Combinational JAL/JALR target selection with JALR bit-0 clear and word-alignment check.
module jump_target_calc
    import jump_redirect_unit_pkg::*;
#(
    parameter int XLEN = BITS32
) (
    input  logic            ex_jal,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_jump_off,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm_i,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] jal_sum;
    logic [XLEN-1:0] jalr_sum;

    assign jal_sum  = ex_pc + ex_jump_off;
    assign jalr_sum = ex_rs1 + ex_imm_i;

    // JAL wins when both decode flags are set; the caller gates on jal|jalr.
    assign target     = ex_jal ? jal_sum : {jalr_sum[XLEN-1:1], 1'b0};
    assign misaligned = target[1];

endmodule

// File: rtl/jump_redirect_unit.sv
// Execute-stage jump handling: captures the jump target and link value, redirects fetch, then flushes.
module jump_redirect_unit
    import jump_redirect_unit_pkg::*;
#(
    parameter int XLEN        = BITS32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_jump_off,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm_i,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_target,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            flush,
    output logic            ex_stall,
    output logic            misalign
);

    localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    jru_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             link_pend;
    logic             misalign_q;
    logic [XLEN-1:0]  target;
    logic             target_misaligned;
    logic             jump;
    logic             capture;
    logic             trap;

    jump_target_calc #(
        .XLEN (XLEN)
    ) u_target_calc (
        .ex_jal      (ex_jal),
        .ex_pc       (ex_pc),
        .ex_jump_off (ex_jump_off),
        .ex_rs1      (ex_rs1),
        .ex_imm_i    (ex_imm_i),
        .target      (target),
        .misaligned  (target_misaligned)
    );

    assign jump    = ex_valid & (ex_jal | ex_jalr);
    assign capture = (state == JRU_IDLE) & jump & ~target_misaligned;
    assign trap    = (state == JRU_IDLE) & jump & target_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= JRU_IDLE;
            cnt        <= '0;
            link_pend  <= FALSE;
            misalign_q <= FALSE;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            link_pend  <= capture;
            misalign_q <= trap;
        end
    end

    // Target and link are held from capture until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_target <= '0;
            link_data    <= '0;
        end else if (capture) begin
            redir_target <= target;
            link_data    <= ex_pc + XLEN'(LINK_INC);
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        redir_valid = FALSE;
        flush       = FALSE;
        ex_stall    = FALSE;
        case (state)
            JRU_IDLE: begin
                if (capture) state_n = JRU_REDIRECT;
            end
            JRU_REDIRECT: begin
                redir_valid = TRUE;
                flush       = TRUE;
                ex_stall    = TRUE;
                if (redir_ready) begin
                    cnt_n   = CNT_W'(FLUSH_DEPTH - 1);
                    state_n = JRU_FLUSH;
                end
            end
            JRU_FLUSH: begin
                flush = TRUE;
                if (cnt == '0) state_n = JRU_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = JRU_IDLE;
        endcase
    end

    assign link_valid = link_pend;
    assign misalign   = misalign_q;

endmodule
